payload_checker: RTL and testbench

Downstream stage of the Ethernet packet detector control FSM. Starts on the payload-enable strobe and captures payload and FCS bytes until the frame-active control line drops. Checks payload length and the CRC-32 frame check sequence, and reports the result to the control FSM via `packet_size_valid`. Maintains a running count of good packets.

---
 rtl/payload_checker.sv | 134 +++++++++++++
 tb/tb_payload_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/payload_checker.sv
// payload_checker: captures payload and FCS bytes after the payload-enable strobe,
// checks payload length and the CRC-32 residue, and counts frames that pass both.
// Optional feature: define PAYLOAD_CHECKER_LENGTH_MATCH_EN to also require the payload
// length to match the latched type/length field (padding to MIN_PAYLOAD accepted).
module payload_checker #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned MIN_PAYLOAD   = 46,
    parameter int unsigned MAX_PAYLOAD   = 1500
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     control,
    input  logic [7:0]               data,
    input  logic [15:0]              type_length,
    output logic                     packet_size_valid,
    output logic                     crc_valid,
    output logic                     frame_done,
    output logic [COUNTER_WIDTH-1:0] valid_packet_counter
);

    typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

    localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
    localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
    localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;
    localparam logic [10:0] CountMax   = 11'h7FF;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    state_e                   state_q;
    logic [10:0]              count_q;
    logic [31:0]              crc_q;
    logic                     size_valid_q;
    logic                     crc_valid_q;
    logic                     done_q;
    logic [COUNTER_WIDTH-1:0] counter_q;

`ifdef PAYLOAD_CHECKER_LENGTH_MATCH_EN
    logic [15:0]              tl_q;
`else
    // Type/length only matters for the length-match check.
    logic                     unused_type_length;
    assign unused_type_length = ^type_length;
`endif

    logic [31:0] len_n;
    logic        size_ok;
    logic        crc_ok;
    logic        start;

    // Frame checks evaluated on the final count/CRC, plus start detection.
    always_comb begin
        len_n   = 32'(count_q) - 32'd4;
        size_ok = (count_q >= 11'd4) && (len_n >= MIN_PAYLOAD) && (len_n <= MAX_PAYLOAD);
`ifdef PAYLOAD_CHECKER_LENGTH_MATCH_EN
        // Values above MAX_PAYLOAD are EtherType codes, not lengths.
        if (32'(tl_q) <= MAX_PAYLOAD) begin
            size_ok = size_ok &&
                      (len_n == ((32'(tl_q) > MIN_PAYLOAD) ? 32'(tl_q) : MIN_PAYLOAD));
        end
`endif
        crc_ok  = (crc_q == CrcResidue);
        start   = enable && control && (state_q != StRecv);
    end

    // Capture FSM with registered result pulses and good-packet counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= 11'd0;
            crc_q        <= CrcInit;
            size_valid_q <= 1'b0;
            crc_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            counter_q    <= '0;
`ifdef PAYLOAD_CHECKER_LENGTH_MATCH_EN
            tl_q         <= 16'h0;
`endif
        end else begin
            size_valid_q <= 1'b0;
            crc_valid_q  <= 1'b0;
            done_q       <= 1'b0;

            // The count lands on the edge that leaves DONE.
            if (state_q == StDone && size_valid_q && crc_valid_q) begin
                counter_q <= counter_q + COUNTER_WIDTH'(1);
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRecv;
                        count_q <= 11'd1;
                        crc_q   <= crc_byte(CrcInit, data);
`ifdef PAYLOAD_CHECKER_LENGTH_MATCH_EN
                        tl_q    <= type_length;
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRecv: begin
                    if (control) begin
                        if (count_q != CountMax) begin
                            count_q <= count_q + 11'd1;
                        end
                        crc_q <= crc_byte(crc_q, data);
                    end else begin
                        state_q      <= StDone;
                        size_valid_q <= size_ok;
                        crc_valid_q  <= crc_ok;
                        done_q       <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign packet_size_valid    = size_valid_q;
    assign crc_valid            = crc_valid_q;
    assign frame_done           = done_q;
    assign valid_packet_counter = counter_q;

endmodule

// File: tb/tb_payload_checker.sv
// Directed bench for payload_checker: builds frames with a bit-serial CRC-32 model,
// streams them one byte per clock and checks the result pulses and packet counter.
module tb_payload_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        control;
    logic [7:0]  data;
    logic [15:0] type_length;
    logic        packet_size_valid;
    logic        crc_valid;
    logic        frame_done;
    logic [15:0] valid_packet_counter;

    payload_checker dut (
        .clock                (clock),
        .reset                (reset),
        .enable               (enable),
        .control              (control),
        .data                 (data),
        .type_length          (type_length),
        .packet_size_valid    (packet_size_valid),
        .crc_valid            (crc_valid),
        .frame_done           (frame_done),
        .valid_packet_counter (valid_packet_counter)
    );

    always #5 clock = ~clock;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [7:0]  fb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Bit-serial reflected CRC-32 over the whole queue.
    function automatic logic [31:0] model_crc(input int len);
        logic [31:0] c;
        logic        fbit;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fbit = c[0] ^ fb[i][b];
                c    = c >> 1;
                if (fbit) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    // Payload of n bytes (constant fill or ramp), then complemented CRC low byte first.
    task automatic build_frame(input int n, input logic [7:0] fill, input bit ramp,
                               input bit corrupt);
        logic [31:0] fcs;
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(ramp ? (8'(i) ^ fill) : fill);
        fcs = ~model_crc(n);
        fb.push_back(fcs[7:0]);
        fb.push_back(fcs[15:8]);
        fb.push_back(fcs[23:16]);
        fb.push_back(fcs[31:24]);
        if (corrupt) fb[n] = fb[n] ^ 8'h01;
    endtask

    // Called just after a negedge; returns at the negedge that drives control low.
    task automatic stream_frame(input logic [15:0] tl);
        type_length = tl;
        enable      = 1'b1;
        control     = 1'b1;
        data        = fb[0];
        for (int i = 1; i < fb.size(); i++) begin
            @(negedge clock);
            enable = 1'b0;
            data   = fb[i];
        end
        @(negedge clock);
        enable  = 1'b0;
        control = 1'b0;
        data    = 8'h00;
    endtask

    task automatic frame_check(input string tag, input logic [15:0] tl,
                               input bit exp_size, input bit exp_crc);
        stream_frame(tl);
        @(negedge clock);
        chk({tag, "_done"}, 32'(frame_done), 32'd1);
        chk({tag, "_size"}, 32'(packet_size_valid), 32'(exp_size));
        chk({tag, "_crc"}, 32'(crc_valid), 32'(exp_crc));
        if (exp_size && exp_crc) exp_cnt = exp_cnt + 16'd1;
        @(negedge clock);
        chk({tag, "_done_clr"}, 32'(frame_done), 32'd0);
        chk({tag, "_cnt"}, 32'(valid_packet_counter), 32'(exp_cnt));
    endtask

    initial begin
        bit exp_b;
        reset       = 1'b1;
        enable      = 1'b0;
        control     = 1'b0;
        data        = 8'h00;
        type_length = 16'h0;
        repeat (2) @(negedge clock);
        chk("rst_size", 32'(packet_size_valid), 32'd0);
        chk("rst_crc", 32'(crc_valid), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_cnt", 32'(valid_packet_counter), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // enable without control in IDLE does nothing.
        enable = 1'b1;
        data   = 8'h55;
        repeat (3) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        chk("idle_en_done", 32'(frame_done), 32'd0);
        chk("idle_en_cnt", 32'(valid_packet_counter), 32'd0);

        // 46 zero bytes, correct FCS.
        build_frame(46, 8'h00, 1'b0, 1'b0);
        frame_check("min_good", 16'h002E, 1'b1, 1'b1);

        // Same frame, first FCS byte flipped.
        build_frame(46, 8'h00, 1'b0, 1'b1);
        frame_check("bad_fcs", 16'h002E, 1'b1, 1'b0);

        // One byte short of the minimum.
        build_frame(45, 8'h3C, 1'b1, 1'b0);
        frame_check("short45", 16'h002D, 1'b0, 1'b1);

        // One byte over the maximum.
        build_frame(1501, 8'hA5, 1'b1, 1'b0);
        frame_check("long1501", 16'h0800, 1'b0, 1'b1);

        // Exactly the maximum.
        build_frame(1500, 8'h5A, 1'b1, 1'b0);
        frame_check("max1500", 16'h05DC, 1'b1, 1'b1);

        // 60-byte payload against a 50-byte length field.
`ifdef PAYLOAD_CHECKER_LENGTH_MATCH_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        build_frame(60, 8'h11, 1'b1, 1'b0);
        frame_check("len_mismatch", 16'h0032, exp_b, 1'b1);

        // Frame too short to even hold an FCS.
        fb.delete();
        fb.push_back(8'hAA);
        fb.push_back(8'h55);
        exp_b = (model_crc(2) == 32'hDEBB_20E3);
        frame_check("tiny2", 16'h002E, 1'b0, exp_b);

        // Back-to-back: second frame starts in the DONE cycle of the first.
        build_frame(46, 8'h00, 1'b0, 1'b0);
        stream_frame(16'h002E);
        @(negedge clock);
        chk("b2b1_done", 32'(frame_done), 32'd1);
        chk("b2b1_size", 32'(packet_size_valid), 32'd1);
        chk("b2b1_crc", 32'(crc_valid), 32'd1);
        exp_cnt = exp_cnt + 16'd1;
        frame_check("b2b2", 16'h002E, 1'b1, 1'b1);

        // Reset while byte 20 is on the bus.
        build_frame(46, 8'h77, 1'b1, 1'b0);
        type_length = 16'h002E;
        enable      = 1'b1;
        control     = 1'b1;
        data        = fb[0];
        for (int i = 1; i < 20; i++) begin
            @(negedge clock);
            enable = 1'b0;
            data   = fb[i];
        end
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        control = 1'b0;
        data    = 8'h00;
        exp_cnt = 16'd0;
        chk("midrst_size", 32'(packet_size_valid), 32'd0);
        chk("midrst_crc", 32'(crc_valid), 32'd0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        chk("midrst_cnt", 32'(valid_packet_counter), 32'd0);
        repeat (3) @(negedge clock);
        chk("midrst_idle_done", 32'(frame_done), 32'd0);
        build_frame(46, 8'h00, 1'b0, 1'b0);
        frame_check("after_rst", 16'h002E, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
